// File: rtl/led_display_arbiter.sv
// Round-robin time-sharing of the 8-bit debug display between NUM_SRC code producers.
// Optional fault preemption is built when LED_DISPLAY_FAULT_PREEMPT_EN is defined.
module led_display_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int DWELL_TICKS = 8,
    parameter int BLANK_TICKS = 1
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   i250mSCE,
    input  logic [NUM_SRC-1:0]     ivSrcValid,
    input  logic [8*NUM_SRC-1:0]   ivSrcData,
    output logic [7:0]             oDisplay,
    output logic                   oBlank,
    output logic [2:0]             oSrcSel,
    output logic                   oFaultPending
);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t     state, state_n;
    logic [2:0] cur, cur_n;
    logic [7:0] cnt, cnt_n;

    logic [7:0] valid;
    logic [7:0] data [8];
    logic [2:0] next_src;
    logic [2:0] low_src;
    logic [2:0] probe;
    logic       any_valid;
    logic       other_valid;
    logic       cur_valid;
    logic       show_now;
    logic       dwell_done;
    logic       gap_done;
    logic       preempt;

    // Sources are padded to 8 so a 3-bit index always lands on a defined slot.
    always_comb begin
        valid = 8'(ivSrcValid);
        for (int j = 0; j < 8; j++) begin
            data[j] = 8'h00;
        end
        for (int j = 0; j < NUM_SRC; j++) begin
            data[j] = ivSrcData[8*j +: 8];
        end
    end

    // Descending loops let the nearest candidate win; the wrap returns cur itself last.
    always_comb begin
        next_src = cur;
        low_src  = 3'd0;
        probe    = 3'd0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            probe = 3'((int'(cur) + i) % NUM_SRC);
            if (valid[probe]) begin
                next_src = probe;
            end
        end
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (valid[3'(j)]) begin
                low_src = 3'(j);
            end
        end
    end

    assign any_valid   = |valid;
    assign cur_valid   = valid[cur];
    assign other_valid = |(valid & ~(8'd1 << cur));
    assign dwell_done  = (cnt == 8'(DWELL_TICKS));
    assign gap_done    = (cnt == 8'(BLANK_TICKS));
    assign show_now    = (state == SHOW) && cur_valid;

`ifdef LED_DISPLAY_FAULT_PREEMPT_EN
    logic fault_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= valid[0];
        end
    end

    assign preempt = valid[0] && !fault_q && (state != IDLE) && (cur != 3'd0);
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cur_n   = cur;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_n = SHOW;
                    cur_n   = low_src;
                    cnt_n   = 8'd0;
                end
            end
            SHOW: begin
                if (preempt) begin
                    cur_n = 3'd0;
                    cnt_n = 8'd0;
                end else if (!cur_valid || (dwell_done && other_valid)) begin
                    cnt_n = 8'd0;
                    if (!any_valid) begin
                        state_n = IDLE;
                    end else if (BLANK_TICKS == 0) begin
                        cur_n = next_src;
                    end else begin
                        state_n = GAP;
                    end
                end else if (dwell_done) begin
                    cnt_n = 8'd0;
                end else if (i250mSCE) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            GAP: begin
                if (preempt) begin
                    state_n = SHOW;
                    cur_n   = 3'd0;
                    cnt_n   = 8'd0;
                end else if (gap_done) begin
                    cnt_n = 8'd0;
                    if (any_valid) begin
                        state_n = SHOW;
                        cur_n   = next_src;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (i250mSCE) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs follow the registered state, gated so an invalid source never reaches the pins.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state         <= IDLE;
            cur           <= 3'd0;
            cnt           <= 8'd0;
            oDisplay      <= 8'h00;
            oBlank        <= 1'b1;
            oSrcSel       <= 3'd0;
            oFaultPending <= 1'b0;
        end else begin
            state         <= state_n;
            cur           <= cur_n;
            cnt           <= cnt_n;
            oDisplay      <= show_now ? data[cur] : 8'h00;
            oBlank        <= !show_now;
            oSrcSel       <= cur;
            oFaultPending <= valid[0] && !(show_now && (cur == 3'd0));
        end
    end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Self-checking bench for led_display_arbiter: direct checks plus a scoreboard of displayed segments.
// Expected preemption behaviour follows LED_DISPLAY_FAULT_PREEMPT_EN.
module tb_led_display_arbiter;

    localparam int NUM_SRC  = 4;
    localparam int DWELL    = 8;
    localparam int BLANK    = 1;
    localparam int TICK_DIV = 5;
    localparam int TIMEOUT  = 3000;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        i250mSCE = 1'b0;
    logic [3:0]  ivSrcValid = 4'b0000;
    logic [31:0] ivSrcData = 32'h0;
    logic [7:0]  oDisplay;
    logic        oBlank;
    logic [2:0]  oSrcSel;
    logic        oFaultPending;

    led_display_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .DWELL_TICKS(DWELL),
        .BLANK_TICKS(BLANK)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .i250mSCE     (i250mSCE),
        .ivSrcValid   (ivSrcValid),
        .ivSrcData    (ivSrcData),
        .oDisplay     (oDisplay),
        .oBlank       (oBlank),
        .oSrcSel      (oSrcSel),
        .oFaultPending(oFaultPending)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic       blank;
        logic [7:0] disp;
        logic [2:0] sel;
        int         ticks;
    } seg_t;

    seg_t exp_q[$];
    seg_t obs_q[$];
    seg_t last_seg;
    seg_t e;
    seg_t o;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   tick_div = 0;
    int   mon_ticks = 0;
    logic mon_en = 1'b0;
    logic mon_started = 1'b0;
    logic prev_tick = 1'b0;
    logic seen_show;

    // One-cycle tick every TICK_DIV clocks, driven just after the rising edge.
    initial begin
        forever begin
            @(posedge iClk);
            #1;
            tick_div++;
            if (tick_div == TICK_DIV) begin
                tick_div = 0;
                i250mSCE = 1'b1;
            end else begin
                i250mSCE = 1'b0;
            end
        end
    end

    // Collects each finished display segment and how many ticks the DUT would have counted in it.
    always @(negedge iClk) begin
        if (!mon_en) begin
            mon_started = 1'b0;
        end else if (!mon_started) begin
            mon_started = 1'b1;
            last_seg = '{oBlank, oDisplay, oSrcSel, 0};
            mon_ticks = 0;
        end else begin
            if ({oBlank, oDisplay, oSrcSel} !== {last_seg.blank, last_seg.disp, last_seg.sel}) begin
                last_seg.ticks = mon_ticks;
                obs_q.push_back(last_seg);
                last_seg = '{oBlank, oDisplay, oSrcSel, 0};
                mon_ticks = 0;
            end
            if (prev_tick) mon_ticks++;
        end
        prev_tick = i250mSCE;
    end

    task automatic do_reset();
        @(posedge iClk);
        #1;
        mon_en = 1'b0;
        iRst = 1'b1;
        ivSrcValid = 4'b0000;
        ivSrcData = 32'h0;
        repeat (3) @(posedge iClk);
        #1;
        iRst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic push_seg(input logic b, input logic [7:0] d, input logic [2:0] s, input int t);
        exp_q.push_back('{b, d, s, t});
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge iClk);
        n_cmp++;
        if ({oBlank, oDisplay, oSrcSel, oFaultPending} !== {1'b1, 8'h00, 3'd0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL reset_vals: got blank=%b disp=%h sel=%0d pend=%b expected 1/00/0/0",
                     oBlank, oDisplay, oSrcSel, oFaultPending);
        end
        for (int i = 0; i < 20; i++) begin
            repeat (TICK_DIV) @(negedge iClk);
            n_cmp++;
            if ({oBlank, oDisplay} !== {1'b1, 8'h00}) begin
                n_bad++;
                $display("[TB] FAIL idle_blank[%0d]: got blank=%b disp=%h expected 1/00", i, oBlank, oDisplay);
            end
        end
    endtask

    task automatic test_single_source();
        do_reset();
        @(posedge iClk);
        #1;
        ivSrcData[23:16] = 8'hA5;
        ivSrcValid = 4'b0100;
        @(posedge iClk);
        @(negedge iClk);
        n_cmp++;
        if (oBlank !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL single_latency1: got blank=%b expected 1", oBlank);
        end
        @(posedge iClk);
        @(negedge iClk);
        n_cmp++;
        if ({oBlank, oDisplay, oSrcSel} !== {1'b0, 8'hA5, 3'd2}) begin
            n_bad++;
            $display("[TB] FAIL single_latency2: got blank=%b disp=%h sel=%0d expected 0/a5/2", oBlank, oDisplay, oSrcSel);
        end
        for (int i = 0; i < 30; i++) begin
            repeat (TICK_DIV) @(negedge iClk);
            n_cmp++;
            if ({oBlank, oDisplay, oSrcSel, oFaultPending} !== {1'b0, 8'hA5, 3'd2, 1'b0}) begin
                n_bad++;
                $display("[TB] FAIL single_hold[%0d]: got blank=%b disp=%h sel=%0d pend=%b expected 0/a5/2/0",
                         i, oBlank, oDisplay, oSrcSel, oFaultPending);
            end
        end
        @(posedge iClk);
        #1;
        ivSrcData[23:16] = 8'h5A;
        @(negedge iClk);
        n_cmp++;
        if (oDisplay !== 8'hA5) begin
            n_bad++;
            $display("[TB] FAIL data_change_early: got %h expected a5", oDisplay);
        end
        @(posedge iClk);
        @(negedge iClk);
        n_cmp++;
        if (oDisplay !== 8'h5A) begin
            n_bad++;
            $display("[TB] FAIL data_change: got %h expected 5a", oDisplay);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        mon_en = 1'b1;
        @(posedge iClk);
        #1;
        ivSrcData[15:8]  = 8'h11;
        ivSrcData[31:24] = 8'h33;
        ivSrcValid = 4'b1010;
        push_seg(1'b1, 8'h00, 3'd0, -1);
        push_seg(1'b0, 8'h11, 3'd1, DWELL);
        push_seg(1'b1, 8'h00, 3'd1, BLANK);
        push_seg(1'b0, 8'h33, 3'd3, DWELL);
        push_seg(1'b1, 8'h00, 3'd3, BLANK);
        push_seg(1'b0, 8'h11, 3'd1, DWELL);
        push_seg(1'b1, 8'h00, 3'd1, BLANK);
        for (int w = 0; w < TIMEOUT && obs_q.size() < exp_q.size(); w++) @(negedge iClk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL rotation_seg: got no segment expected disp=%h sel=%0d", e.disp, e.sel);
            end else begin
                o = obs_q.pop_front();
                if ({o.blank, o.disp, o.sel} !== {e.blank, e.disp, e.sel}) begin
                    n_bad++;
                    $display("[TB] FAIL rotation_seg: got %b/%h/%0d expected %b/%h/%0d",
                             o.blank, o.disp, o.sel, e.blank, e.disp, e.sel);
                end
                if (e.ticks >= 0) begin
                    n_cmp++;
                    if (o.ticks !== e.ticks) begin
                        n_bad++;
                        $display("[TB] FAIL rotation_ticks: got %0d expected %0d (disp=%h)", o.ticks, e.ticks, e.disp);
                    end
                end
            end
        end
        mon_en = 1'b0;
    endtask

    task automatic test_valid_drop();
        do_reset();
        mon_en = 1'b1;
        @(posedge iClk);
        #1;
        ivSrcData[15:8]  = 8'h11;
        ivSrcData[31:24] = 8'h33;
        ivSrcValid = 4'b1000;
        push_seg(1'b1, 8'h00, 3'd0, -1);
        push_seg(1'b0, 8'h33, 3'd3, -1);
        push_seg(1'b1, 8'h00, 3'd3, -1);
        for (int w = 0; w < TIMEOUT; w++) begin
            @(posedge iClk);
            #1;
            if (!oBlank && oDisplay == 8'h33) break;
        end
        ivSrcValid = 4'b1010;
        for (int w = 0; w < TIMEOUT; w++) begin
            @(posedge iClk);
            #1;
            if (!oBlank && oDisplay == 8'h33 && mon_ticks >= 3) break;
        end
        ivSrcValid = 4'b0010;
        @(posedge iClk);
        @(posedge iClk);
        @(negedge iClk);
        n_cmp++;
        if ({oBlank, oSrcSel} !== {1'b1, 3'd3}) begin
            n_bad++;
            $display("[TB] FAIL drop_gap: got blank=%b sel=%0d expected 1/3", oBlank, oSrcSel);
        end
        for (int w = 0; w < TIMEOUT && obs_q.size() < exp_q.size(); w++) @(negedge iClk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL drop_seg: got no segment expected disp=%h sel=%0d", e.disp, e.sel);
            end else begin
                o = obs_q.pop_front();
                if ({o.blank, o.disp, o.sel} !== {e.blank, e.disp, e.sel}) begin
                    n_bad++;
                    $display("[TB] FAIL drop_seg: got %b/%h/%0d expected %b/%h/%0d",
                             o.blank, o.disp, o.sel, e.blank, e.disp, e.sel);
                end
            end
        end
        @(posedge iClk);
        #1;
        n_cmp++;
        if ({oBlank, oDisplay, oSrcSel} !== {1'b0, 8'h11, 3'd1}) begin
            n_bad++;
            $display("[TB] FAIL drop_next: got %b/%h/%0d expected 0/11/1", oBlank, oDisplay, oSrcSel);
        end
        mon_en = 1'b0;
    endtask

    task automatic test_fault();
        do_reset();
        mon_en = 1'b1;
        @(posedge iClk);
        #1;
        ivSrcData[7:0]   = 8'hE7;
        ivSrcData[23:16] = 8'hC3;
        ivSrcValid = 4'b0100;
        push_seg(1'b1, 8'h00, 3'd0, -1);
`ifdef LED_DISPLAY_FAULT_PREEMPT_EN
        push_seg(1'b0, 8'hC3, 3'd2, -1);
        push_seg(1'b0, 8'hE7, 3'd0, DWELL);
        push_seg(1'b1, 8'h00, 3'd0, BLANK);
`else
        push_seg(1'b0, 8'hC3, 3'd2, DWELL);
        push_seg(1'b1, 8'h00, 3'd2, BLANK);
        push_seg(1'b0, 8'hE7, 3'd0, DWELL);
        push_seg(1'b1, 8'h00, 3'd0, BLANK);
`endif
        for (int w = 0; w < TIMEOUT; w++) begin
            @(posedge iClk);
            #1;
            if (!oBlank && oDisplay == 8'hC3 && mon_ticks >= 2) break;
        end
        ivSrcValid = 4'b0101;
        @(posedge iClk);
        @(negedge iClk);
        n_cmp++;
        if ({oBlank, oDisplay, oSrcSel, oFaultPending} !== {1'b0, 8'hC3, 3'd2, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL fault_cycle1: got %b/%h/%0d pend=%b expected 0/c3/2 pend=1",
                     oBlank, oDisplay, oSrcSel, oFaultPending);
        end
        @(posedge iClk);
        @(negedge iClk);
        n_cmp++;
`ifdef LED_DISPLAY_FAULT_PREEMPT_EN
        if ({oBlank, oDisplay, oSrcSel, oFaultPending} !== {1'b0, 8'hE7, 3'd0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL fault_cycle2: got %b/%h/%0d pend=%b expected 0/e7/0 pend=0",
                     oBlank, oDisplay, oSrcSel, oFaultPending);
        end
`else
        if ({oBlank, oDisplay, oSrcSel, oFaultPending} !== {1'b0, 8'hC3, 3'd2, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL fault_cycle2: got %b/%h/%0d pend=%b expected 0/c3/2 pend=1",
                     oBlank, oDisplay, oSrcSel, oFaultPending);
        end
`endif
        for (int w = 0; w < TIMEOUT && obs_q.size() < exp_q.size(); w++) @(negedge iClk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL fault_seg: got no segment expected disp=%h sel=%0d", e.disp, e.sel);
            end else begin
                o = obs_q.pop_front();
                if ({o.blank, o.disp, o.sel} !== {e.blank, e.disp, e.sel}) begin
                    n_bad++;
                    $display("[TB] FAIL fault_seg: got %b/%h/%0d expected %b/%h/%0d",
                             o.blank, o.disp, o.sel, e.blank, e.disp, e.sel);
                end
                if (e.ticks >= 0) begin
                    n_cmp++;
                    if (o.ticks !== e.ticks) begin
                        n_bad++;
                        $display("[TB] FAIL fault_ticks: got %0d expected %0d (disp=%h)", o.ticks, e.ticks, e.disp);
                    end
                end
            end
        end
        @(posedge iClk);
        #1;
        n_cmp++;
        if ({oBlank, oDisplay, oSrcSel, oFaultPending} !== {1'b0, 8'hC3, 3'd2, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL fault_resume: got %b/%h/%0d pend=%b expected 0/c3/2 pend=1",
                     oBlank, oDisplay, oSrcSel, oFaultPending);
        end
        mon_en = 1'b0;
    endtask

    task automatic test_reset_in_gap();
        do_reset();
        @(posedge iClk);
        #1;
        ivSrcData = 32'h3300_115C;
        ivSrcValid = 4'b1010;
        seen_show = 1'b0;
        for (int w = 0; w < TIMEOUT; w++) begin
            @(posedge iClk);
            #1;
            if (!oBlank) seen_show = 1'b1;
            if (seen_show && oBlank) break;
        end
        n_cmp++;
        if ({seen_show, oBlank} !== 2'b11) begin
            n_bad++;
            $display("[TB] FAIL gap_reached: got seen=%b blank=%b expected 1/1", seen_show, oBlank);
        end
        iRst = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        n_cmp++;
        if ({oBlank, oDisplay, oSrcSel, oFaultPending} !== {1'b1, 8'h00, 3'd0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL gap_reset: got %b/%h/%0d pend=%b expected 1/00/0 pend=0",
                     oBlank, oDisplay, oSrcSel, oFaultPending);
        end
        ivSrcValid = 4'b0001;
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        @(posedge iClk);
        @(negedge iClk);
        n_cmp++;
        if (oBlank !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL release_latency1: got blank=%b expected 1", oBlank);
        end
        @(posedge iClk);
        @(negedge iClk);
        n_cmp++;
        if ({oBlank, oDisplay, oSrcSel, oFaultPending} !== {1'b0, 8'h5C, 3'd0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL release_src0: got %b/%h/%0d pend=%b expected 0/5c/0 pend=0",
                     oBlank, oDisplay, oSrcSel, oFaultPending);
        end
    endtask

    initial begin
        $display("[TB] led_display_arbiter bench start");
        test_reset();
        test_single_source();
        test_rotation();
        test_valid_drop();
        test_fault();
        test_reset_in_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_display_arbiter.md
# led_display_arbiter

Time-shares the 8-bit debug LED/seven-segment display between up to NUM_SRC code producers: fault code, PFR platform state, BIOS POST code, CPLD sequencer stage. Each valid source is shown round-robin for a fixed dwell, measured in 250 ms clock-enable ticks, with a blank gap between sources. Sits between the fault-code converter, the other status producers and the display output pins.

## Interface
- NUM_SRC, 4: number of requesting sources (2..8); source 0 is the fault source.
- DWELL_TICKS, 8: i250mSCE ticks each source is displayed (1..255).
- BLANK_TICKS, 1: i250mSCE ticks of blank between sources (0..15; 0 = no gap).
- iClk  in  1  system clock; the only clock.
- iRst  in  1  synchronous, active-high reset.
- i250mSCE  in  1  one-cycle 250 ms clock enable.
- ivSrcValid  in  NUM_SRC  per-source "has code to show", level.
- ivSrcData  in  8*NUM_SRC  source n code on bits [8n+7:8n].
- oDisplay  out  8  code driven to the display.
- oBlank  out  1  display blanked (oDisplay = 8'h00).
- oSrcSel  out  3  index of the source currently shown.
- oFaultPending  out  1  ivSrcValid[0] high and source 0 not currently shown.

## Operation
- States: IDLE, SHOW, GAP. Dwell/gap counter is 8-bit. Current index cur is 3-bit.
- Reset values: state IDLE, cur 0, counter 0, oDisplay 8'h00, oBlank 1, oSrcSel 0, oFaultPending 0.
- Next-source search: round-robin over valid sources, starting at cur+1 mod NUM_SRC. The search wraps and may return cur itself if cur is the only valid source.
- IDLE: blank. On any ivSrcValid bit high, load cur with the lowest-index valid source, clear the counter, go to SHOW.
- SHOW:
  - oDisplay tracks ivSrcData[cur] live.
  - Counter increments on i250mSCE.
  - When the counter reaches DWELL_TICKS and another source is valid: go to GAP, or straight to SHOW of the next source if BLANK_TICKS=0, and clear the counter.
  - When the counter reaches DWELL_TICKS and no other source is valid: stay in SHOW and clear the counter.
- GAP: blank. Counter increments on i250mSCE. At BLANK_TICKS, load cur with the next valid source and go to SHOW with the counter cleared. If no source is valid at that point, go to IDLE.
- cur source drops valid in SHOW: go to GAP the next cycle (or the next SHOW when BLANK_TICKS=0; IDLE if none valid). The counter is not required to have expired.
- Simultaneous dwell expiry and valid drop: the valid drop wins; behaviour is identical.
- ivSrcValid bits at or above NUM_SRC do not exist. Data of invalid sources is never displayed.
- Reset mid-dwell or mid-gap returns to the reset values the next cycle.

## Timing
- All outputs are registered. oDisplay, oBlank and oSrcSel change one iClk after the state/data that causes them.
- A source data change while shown appears on oDisplay one cycle later.
- IDLE→SHOW: first valid at cycle N gives oBlank=0 with the code at N+2 (state update, then output register).
- Dwell duration is exactly DWELL_TICKS i250mSCE pulses after entry to SHOW. Pulses on the entry cycle are not counted.
- oFaultPending is registered, with the same one-cycle latency.

## Configuration
- LED_DISPLAY_FAULT_PREEMPT_EN defined:
  - A 0→1 edge of ivSrcValid[0] while SHOW or GAP has cur≠0 forces cur=0 and SHOW on the next cycle.
  - The gap is skipped and the counter cleared.
  - Rotation resumes from source 1 afterwards.
- LED_DISPLAY_FAULT_PREEMPT_EN not defined: source 0 waits its round-robin turn like any other source. The edge detector register is not built.

## Test plan
- Reset with ivSrcValid=4'b0000 → oBlank=1, oDisplay=8'h00, oSrcSel=0; stays blank over 20 ticks.
- Only src2 valid, data 8'hA5, DWELL_TICKS=8 → oDisplay=8'hA5 two cycles after valid; oSrcSel=2 held indefinitely with no gap.
- Src1 (8'h11) and src3 (8'h33) valid, BLANK_TICKS=1 → sequence 11 for 8 ticks, blank for 1 tick, 33 for 8 ticks, blank, 11 (wrap).
- Src3 shown, its valid drops mid-dwell at tick 3 while src1 is valid → GAP the next cycle, then 8'h11.
- Src2 shown at tick 2, ivSrcValid[0] rises with 8'hE7:
  - Macro defined → oDisplay=8'hE7, oSrcSel=0 two cycles later, no blank.
  - Macro undefined → E7 only after src2's dwell and the gap; oFaultPending=1 meanwhile.
- iRst asserted during GAP → next cycle all outputs at reset values. Re-release with src0 valid → SHOW src0.
